// File: rtl/mod_exp_pkg.sv
// Shared types and timing constants for the modular exponentiation engine.
// Latency constants assume the default 8-bit operand width.
package mod_exp_pkg;

  localparam int WIDTH         = 8;
  localparam int MODMUL_CYCLES = WIDTH + 1;
  localparam int FIXED_LATENCY = (2 * WIDTH + 1) * MODMUL_CYCLES + 1;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    MUL,
    SQR,
    FIN
  } state_e;

endpackage

// File: rtl/mod_mul_serial.sv
// Interleaved shift-add modular multiplier: r = a*b mod n, b scanned MSB first.
// One load cycle plus WIDTH iterations; done flags the final iteration, r carries its result.
module mod_mul_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] r
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = WIDTH + 2;

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    nx, t0, t1, t2;

  always_comb begin
    nx = {2'b00, n_q};
    // With acc < n and a < n, 2*acc + a < 3n, so two conditional subtracts suffice.
    t0 = (acc_q << 1) + (b_q[WIDTH-1] ? {2'b00, a_q} : '0);
    t1 = (t0 >= nx) ? t0 - nx : t0;
    t2 = (t1 >= nx) ? t1 - nx : t1;

    busy_d = busy_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    n_d    = n_q;
    acc_d  = acc_q;

    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(WIDTH);
      a_d    = a;
      b_d    = b;
      n_d    = n;
      acc_d  = '0;
    end else if (busy_q) begin
      acc_d = t2;
      b_d   = {b_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      n_q    <= n_d;
      acc_q  <= acc_d;
    end
  end

  assign done = busy_q && (cnt_q == CW'(1));
  assign r    = t2[WIDTH-1:0];

endmodule

// File: rtl/mod_exp_unit.sv
// Right-to-left square-and-multiply engine computing c = p^e mod n over one shared serial multiplier.
// Define MODEXP_EARLY_EXIT_EN to finish as soon as no higher exponent bits remain.
module mod_exp_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic             err
);

  import mod_exp_pkg::*;

  localparam int BW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] p_q, p_d, e_q, e_d, n_q, n_d;
  logic [WIDTH-1:0] base_q, base_d, res_q, res_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             done_q, done_d, err_q, err_d;
  logic             kick_q, kick_d;
  logic [WIDTH-1:0] mul_a, mul_b, mul_r;
  logic             mul_done;
  logic             last_bit;

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (kick_q),
    .a     (mul_a),
    .b     (mul_b),
    .n     (n_q),
    .done  (mul_done),
    .r     (mul_r)
  );

`ifdef MODEXP_EARLY_EXIT_EN
  assign last_bit = (((e_q >> bit_q) >> 1) == '0);
`else
  assign last_bit = (bit_q == BW'(WIDTH - 1));
`endif

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    p_d     = p_q;
    e_d     = e_q;
    n_d     = n_q;
    base_d  = base_q;
    res_d   = res_q;
    c_d     = c_q;
    err_d   = err_q;
    done_d  = 1'b0;
    kick_d  = 1'b0;
    mul_a   = res_q;
    mul_b   = base_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          p_d     = p;
          e_d     = e;
          n_d     = n;
          bit_d   = '0;
          kick_d  = 1'b1;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        mul_a = WIDTH'(1);
        mul_b = p_q;
        if (mul_done) begin
          base_d = mul_r;
          res_d  = WIDTH'(1);
`ifdef MODEXP_EARLY_EXIT_EN
          if (e_q == '0) begin
            state_d = FIN;
          end else begin
            kick_d  = 1'b1;
            state_d = MUL;
          end
`else
          kick_d  = 1'b1;
          state_d = MUL;
`endif
        end
      end
      MUL: begin
        if (mul_done) begin
          if (e_q[bit_q]) begin
            res_d = mul_r;
          end
          kick_d  = 1'b1;
          state_d = SQR;
        end
      end
      SQR: begin
        mul_a = base_q;
        if (mul_done) begin
          base_d = mul_r;
          if (last_bit) begin
            state_d = FIN;
          end else begin
            bit_d   = bit_q + BW'(1);
            kick_d  = 1'b1;
            state_d = MUL;
          end
        end
      end
      FIN: begin
        // Moduli 0 and 1 have no meaningful residue; report zero with err.
        err_d   = (n_q < WIDTH'(2));
        c_d     = err_d ? '0 : res_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      p_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      base_q  <= '0;
      res_q   <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      kick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      p_q     <= p_d;
      e_q     <= e_d;
      n_q     <= n_d;
      base_q  <= base_d;
      res_q   <= res_d;
      c_q     <= c_d;
      err_q   <= err_d;
      done_q  <= done_d;
      kick_q  <= kick_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign c    = c_q;
  assign err  = err_q;

endmodule

// File: tb/tb_mod_exp_unit.sv
// Scoreboard bench for mod_exp_unit: directed vectors push expected results, a monitor checks each done.
module tb_mod_exp_unit;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] p, e, n;
  logic         busy, done, err;
  logic [W-1:0] c;

  mod_exp_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .p     (p),
    .e     (e),
    .n     (n),
    .busy  (busy),
    .done  (done),
    .c     (c),
    .err   (err)
  );

  typedef struct {
    logic [W-1:0] c;
    logic         err;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  logic idle_req = 1'b0;
  logic tmo_req  = 1'b0;
  logic cnt_req  = 1'b0;
  int   cnt_exp  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic int exp_lat(input logic [W-1:0] ee);
    int k;
    k = W;
`ifdef MODEXP_EARLY_EXIT_EN
    k = 0;
    for (int i = 0; i < W; i++) begin
      if (ee[i]) k = i + 1;
    end
`else
    if (ee == '0) k = W;
`endif
    return (2 * k + 1) * (W + 1) + 1;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks = n_checks + 1;
    if (act != req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: the only process that evaluates comparisons.
  initial forever begin
    exp_t x;
    @(negedge clk);
    if (idle_req) begin
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_c", int'(c), 0);
      chk("reset_err", int'(err), 0);
    end
    if (tmo_req) begin
      chk("done_timeout", 0, 1);
      sb_q.delete();
    end
    if (cnt_req) begin
      chk("done_pulse_count", done_cnt, cnt_exp);
    end
    if (rst_n && done) begin
      done_cnt = done_cnt + 1;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        x = sb_q.pop_front();
        chk("result_c", int'(c), int'(x.c));
        chk("result_err", int'(err), int'(x.err));
        chk("latency", cyc - x.acc, x.lat);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic launch(input logic [W-1:0] pp, input logic [W-1:0] ee, input logic [W-1:0] nn,
                        output int acc);
    @(negedge clk);
    p = pp;
    e = ee;
    n = nn;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0;
    p = W'($urandom);
    e = W'($urandom);
    n = W'($urandom);
  endtask

  task automatic issue(input logic [W-1:0] pp, input logic [W-1:0] ee, input logic [W-1:0] nn,
                       input logic [W-1:0] ec, input logic eerr);
    exp_t x;
    int   acc;
    launch(pp, ee, nn, acc);
    x.c   = ec;
    x.err = eerr;
    x.acc = acc;
    x.lat = exp_lat(ee);
    sb_q.push_back(x);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 400) begin
      @(posedge clk);
      k = k + 1;
    end
    if (sb_q.size() != 0) begin
      tmo_req = 1'b1;
      @(negedge clk);
      #1;
      tmo_req = 1'b0;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic req_idle_check();
    idle_req = 1'b1;
    @(negedge clk);
    #1;
    idle_req = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] p, e, n, c;
    logic         err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int acc;
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    p = '0;
    e = '0;
    n = '0;
    #2;
    req_idle_check();
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{p: 8'd2,   e: 8'd7,   n: 8'd33,  c: 8'd29, err: 1'b0});
    vecs.push_back('{p: 8'd200, e: 8'd1,   n: 8'd33,  c: 8'd2,  err: 1'b0});
    vecs.push_back('{p: 8'd3,   e: 8'd200, n: 8'd7,   c: 8'd2,  err: 1'b0});
    vecs.push_back('{p: 8'd5,   e: 8'd3,   n: 8'd13,  c: 8'd8,  err: 1'b0});
    vecs.push_back('{p: 8'd9,   e: 8'd0,   n: 8'd33,  c: 8'd1,  err: 1'b0});
    vecs.push_back('{p: 8'd0,   e: 8'd5,   n: 8'd33,  c: 8'd0,  err: 1'b0});
    vecs.push_back('{p: 8'd5,   e: 8'd3,   n: 8'd0,   c: 8'd0,  err: 1'b1});
    vecs.push_back('{p: 8'd5,   e: 8'd3,   n: 8'd1,   c: 8'd0,  err: 1'b1});
    vecs.push_back('{p: 8'd7,   e: 8'd2,   n: 8'd10,  c: 8'd9,  err: 1'b0});
    vecs.push_back('{p: 8'd12,  e: 8'd2,   n: 8'd12,  c: 8'd0,  err: 1'b0});
    vecs.push_back('{p: 8'd255, e: 8'd2,   n: 8'd254, c: 8'd1,  err: 1'b0});
    vecs.push_back('{p: 8'd254, e: 8'd2,   n: 8'd255, c: 8'd1,  err: 1'b0});

    foreach (vecs[i]) begin
      issue(vecs[i].p, vecs[i].e, vecs[i].n, vecs[i].c, vecs[i].err);
      wait_done();
    end

    // A second start while busy must be dropped.
    d0 = done_cnt;
    issue(8'd2, 8'd7, 8'd33, 8'd29, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    p = 8'd5;
    e = 8'd3;
    n = 8'd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (200) @(posedge clk);
    cnt_exp = d0 + 1;
    cnt_req = 1'b1;
    @(negedge clk);
    #1;
    cnt_req = 1'b0;

    // Reset in the middle of an operation clears everything at once.
    launch(8'd3, 8'd200, 8'd7, acc);
    repeat (50) @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_idle_check();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'd5, 8'd3, 8'd13, 8'd8, 1'b0);
    wait_done();

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_exp_unit.md
Name: mod_exp_unit

Overview:
- Sequential modular exponentiation engine: computes c = p^e mod n for unsigned WIDTH-bit operands.
- Serves as the encryption/decryption primitive for the small-RSA datapath.
- Uses right-to-left binary square-and-multiply, built on an iterative shift-add modular multiplier.
- Start/done handshake; one operation in flight at a time.

Parameters:
- WIDTH, 8, bit width of p, e, n and c.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only while busy=0
- p  input  WIDTH  plaintext/base; any value, including p >= n
- e  input  WIDTH  exponent
- n  input  WIDTH  modulus
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when c is updated
- c  output  WIDTH  result register; holds its value until the next done
- err  output  1  registered with done; high when n < 2

Behaviour:
- Reset (async, rst_n=0): busy=0, done=0, c=0, err=0; FSM to IDLE; any operation in progress is discarded.
- Operand capture: p, e, n are latched on the accepting edge (start=1, busy=0). Later input changes have no effect on that operation.
- Start while busy: ignored.
- FSM states and transitions:
  - IDLE -> REDUCE on an accepted start.
  - REDUCE: base = p mod n, computed as modmul(1, p). Result register res = 1.
  - For each exponent bit i = 0..WIDTH-1, LSB first:
    - MUL: compute res*base mod n; commit it to res only if e[i]=1.
    - SQR: base = base*base mod n.
  - FIN -> IDLE, pulsing done.
- Modular multiply, modmul(a, b):
  - Requires a < n.
  - Scans b MSB first.
  - Per bit: r = 2r + (b[j] ? a : 0), then subtract n while r >= n (at most twice).
  - Intermediate width is WIDTH+2 bits; no overflow.
  - Each modmul occupies exactly WIDTH+1 cycles (1 load cycle + WIDTH iterations).
- Latency: all WIDTH exponent bits are always processed, so latency is fixed. done asserts exactly (2*WIDTH+1)*(WIDTH+1)+1 cycles after the accepting edge (154 for WIDTH=8). busy falls in the same cycle done rises.
- Boundary conditions:
  - e = 0: c = 1 (n >= 2).
  - p = 0 and e > 0: c = 0.
  - p >= n: reduced first.
  - n = 1 or n = 0: the datapath is bypassed; FIN is still reached at the same fixed latency, with c = 0 and err = 1.
  - Otherwise err = 0.
- Output timing: done, err and c update on the same edge.

Optional Feature:
- MODEXP_EARLY_EXIT_EN defined: after each SQR, if all remaining higher exponent bits are zero, go directly to FIN.
  - Latency becomes variable: (2*k+1)*(WIDTH+1)+1, where k = index of the highest set bit of e, plus 1. For e = 0, k = 0.
  - Results are unchanged.
- Macro undefined: fixed latency as specified above.

Decomposition:
- Package mod_exp_pkg holds:
  - the FSM state enum (IDLE, REDUCE, MUL, SQR, FIN);
  - localparam MODMUL_CYCLES = WIDTH+1;
  - localparam FIXED_LATENCY.
- Sub-module mod_mul_serial: the interleaved shift-add modular multiplier.
  - Ports: clk, rst_n, start, a, b, n, done, r.
  - Instantiated once; the controller multiplexes its operands.

Test Plan:
- p=2, e=7, n=33, start -> done exactly 154 cycles later; c=29, err=0.
- p=200, e=1, n=33 -> c=2 (p pre-reduced); p=3, e=200, n=7 -> c=2; p=5, e=3, n=13 -> c=8.
- p=9, e=0, n=33 -> c=1; p=0, e=5, n=33 -> c=0.
- n=0 and n=1 (p=5, e=3) -> c=0, err=1, at the same fixed latency.
- Pulse start again 10 cycles into an operation with different operands -> ignored; the first result is unchanged and only one done pulse occurs.
- Assert rst_n low mid-operation -> busy/done/c/err clear immediately; a new start after release yields the correct result. Under MODEXP_EARLY_EXIT_EN: e=1 -> done at 28 cycles.
